// File: rtl/text_banner_ctrl.sv
// rtl/text_banner_ctrl.sv - frame-timed text banner sequencer with slot decode for a shared glyph renderer
module text_banner_ctrl #(
  parameter int NUM_CHARS    = 4,
  parameter int CHAR_W       = 26,
  parameter int CHAR_H       = 40,
  parameter int GAP          = 6,
  parameter int SHOW_FRAMES  = 180,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        show_req,
  input  logic        cancel,
  input  logic        blink_en,
  input  logic [9:0]  base_x,
  input  logic [9:0]  base_y,
  input  logic        glyph_hit,
  output logic [31:0] glyph_start_x,
  output logic [31:0] glyph_start_y,
  output logic [2:0]  slot_idx,
  output logic        slot_valid,
  output logic        pixel_on,
  output logic        show_ack,
  output logic        busy,
  output logic        done
);

  localparam int P  = CHAR_W + GAP;
  localparam int FW = $clog2(SHOW_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHOW_ON  = 2'd1,
    S_SHOW_OFF = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;
  logic [9:0]    base_x_q;
  logic [9:0]    base_y_q;
  logic          blink_en_q;
  logic          accept;
  logic          expire;
  logic          blink_wrap;
  logic          frame_adv;
  logic [9:0]    dx;
  logic [9:0]    dy;
  logic [31:0]   dx32;
  logic [31:0]   dy32;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: cancel beats everything, expiry beats the blink toggle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    expire     = 1'b0;
    blink_wrap = 1'b0;
    frame_adv  = 1'b0;
    case (state)
      S_IDLE: begin
        if (show_req && !cancel) begin
          next_state = S_SHOW_ON;
          accept     = 1'b1;
        end
      end
      default: begin
        if (cancel) begin
          next_state = S_IDLE;
        end else if (frame_tick) begin
          frame_adv = 1'b1;
          if (frame_cnt == FW'(SHOW_FRAMES - 1)) begin
            expire     = 1'b1;
            next_state = S_IDLE;
          end else if (blink_en_q && (blink_cnt == BW'(BLINK_FRAMES - 1))) begin
            blink_wrap = 1'b1;
            next_state = (state == S_SHOW_ON) ? S_SHOW_OFF : S_SHOW_ON;
          end
        end
      end
    endcase
  end

  // Frame/blink counters and the banner parameters captured on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      blink_en_q <= 1'b0;
    end else if (accept) begin
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      base_x_q   <= base_x;
      base_y_q   <= base_y;
      blink_en_q <= blink_en;
    end else if (frame_adv) begin
      frame_cnt <= frame_cnt + 1'b1;
      if (blink_en_q && !expire) begin
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      end
    end
  end

  // Slot decode: one comparator pair per slot against the latched origin.
  always_comb begin
    dx         = x - base_x_q;
    dy         = y - base_y_q;
    dx32       = {22'd0, dx};
    dy32       = {22'd0, dy};
    slot_valid = 1'b0;
    slot_idx   = 3'd0;
    if ((x >= base_x_q) && (y >= base_y_q) && (dy32 < 32'(CHAR_H))) begin
      for (int k = 0; k < NUM_CHARS; k++) begin
        if ((dx32 >= 32'(k * P)) && (dx32 < 32'(k * P + CHAR_W))) begin
          slot_valid = 1'b1;
          slot_idx   = 3'(k);
        end
      end
    end
  end

  assign glyph_start_x = {22'd0, base_x_q} + 32'(slot_idx) * 32'(P);
  assign glyph_start_y = {22'd0, base_y_q};
  assign busy          = (state != S_IDLE);

  // Registered pixel and handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on <= 1'b0;
      show_ack <= 1'b0;
      done     <= 1'b0;
    end else begin
      pixel_on <= (state == S_SHOW_ON) && slot_valid && glyph_hit;
      show_ack <= accept;
      done     <= expire;
    end
  end

endmodule

// File: tb/tb_text_banner_ctrl.sv
// tb/tb_text_banner_ctrl.sv - self-checking bench for text_banner_ctrl
module tb_text_banner_ctrl;

  localparam int NUM_CHARS    = 4;
  localparam int CHAR_W       = 26;
  localparam int CHAR_H       = 40;
  localparam int GAP          = 6;
  localparam int SHOW_FRAMES  = 180;
  localparam int BLINK_FRAMES = 30;
  localparam int P            = CHAR_W + GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        show_req = 1'b0;
  logic        cancel = 1'b0;
  logic        blink_en = 1'b0;
  logic [9:0]  base_x = '0;
  logic [9:0]  base_y = '0;
  logic        glyph_hit = 1'b0;
  logic [31:0] glyph_start_x;
  logic [31:0] glyph_start_y;
  logic [2:0]  slot_idx;
  logic        slot_valid;
  logic        pixel_on;
  logic        show_ack;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  text_banner_ctrl #(
    .NUM_CHARS(NUM_CHARS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .GAP(GAP),
    .SHOW_FRAMES(SHOW_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .x(x), .y(y),
    .show_req(show_req), .cancel(cancel), .blink_en(blink_en),
    .base_x(base_x), .base_y(base_y), .glyph_hit(glyph_hit),
    .glyph_start_x(glyph_start_x), .glyph_start_y(glyph_start_y),
    .slot_idx(slot_idx), .slot_valid(slot_valid), .pixel_on(pixel_on),
    .show_ack(show_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: banner age in frames, visibility from age / half-period parity.
  bit m_busy, m_blink, m_ack, m_done, m_pix;
  int m_ticks, m_bx, m_by;

  function automatic void slot_of(input int xx, input int yy, input int bx, input int by,
                                  output bit v, output int idx);
    int ddx;
    int ddy;
    v   = 1'b0;
    idx = 0;
    if (xx >= bx && yy >= by) begin
      ddx = xx - bx;
      ddy = yy - by;
      if (ddy < CHAR_H && (ddx / P) < NUM_CHARS && (ddx % P) < CHAR_W) begin
        v   = 1'b1;
        idx = ddx / P;
      end
    end
  endfunction

  function automatic bit visible();
    return !m_blink || (((m_ticks / BLINK_FRAMES) % 2) == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit v;
    int idx;
    if (!rst_n) begin
      m_busy = 0; m_blink = 0; m_ack = 0; m_done = 0; m_pix = 0;
      m_ticks = 0; m_bx = 0; m_by = 0;
    end else begin
      slot_of(int'(x), int'(y), m_bx, m_by, v, idx);
      m_pix  = m_busy && visible() && v && glyph_hit;
      m_ack  = 0;
      m_done = 0;
      if (!m_busy) begin
        if (show_req && !cancel) begin
          m_busy = 1; m_ticks = 0; m_ack = 1;
          m_bx = int'(base_x); m_by = int'(base_y); m_blink = blink_en;
        end
      end else if (cancel) begin
        m_busy = 0;
      end else if (frame_tick) begin
        m_ticks++;
        if (m_ticks == SHOW_FRAMES) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    bit v;
    int idx;
    if (rst_n) begin
      slot_of(int'(x), int'(y), m_bx, m_by, v, idx);
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("show_ack", {31'd0, show_ack}, {31'd0, m_ack});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("pixel_on", {31'd0, pixel_on}, {31'd0, m_pix});
      chk("slot_valid", {31'd0, slot_valid}, {31'd0, v});
      chk("slot_idx", {29'd0, slot_idx}, 32'(idx));
      chk("glyph_start_x", glyph_start_x, 32'(m_bx + idx * P));
      chk("glyph_start_y", glyph_start_y, 32'(m_by));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(2);
    end
  endtask

  task automatic last_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pixel_on", {31'd0, pixel_on}, 32'd0);
    chk("reset_show_ack", {31'd0, show_ack}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_gsx", glyph_start_x, 32'd0);

    // Basic accept and slot decode at base (100,50).
    base_x = 10'd100; base_y = 10'd50; blink_en = 1'b0; show_req = 1'b1;
    step(1);
    show_req = 1'b0;
    chk("accept_ack", {31'd0, show_ack}, 32'd1);
    chk("accept_busy", {31'd0, busy}, 32'd1);
    x = 10'd133; y = 10'd60; #1;
    chk("slot1_valid", {31'd0, slot_valid}, 32'd1);
    chk("slot1_idx", {29'd0, slot_idx}, 32'd1);
    chk("slot1_gsx", glyph_start_x, 32'd132);
    chk("slot1_gsy", glyph_start_y, 32'd50);
    chk("model_base_x", 32'(m_bx), 32'd100);
    x = 10'd127; #1;
    chk("gap_invalid", {31'd0, slot_valid}, 32'd0);
    x = 10'd133; y = 10'd90; #1;
    chk("below_invalid", {31'd0, slot_valid}, 32'd0);
    glyph_hit = 1'b1; y = 10'd60;
    step(1);
    chk("pixel_latency", {31'd0, pixel_on}, 32'd1);
    do_ticks(SHOW_FRAMES - 1);
    chk("busy_before_expiry", {31'd0, busy}, 32'd1);
    last_tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    step(1);
    chk("done_single", {31'd0, done}, 32'd0);
    chk("pixel_off_idle", {31'd0, pixel_on}, 32'd0);

    // Blinking banner.
    blink_en = 1'b1; show_req = 1'b1;
    step(1);
    show_req = 1'b0; blink_en = 1'b0;
    step(1);
    chk("blink_t0", {31'd0, pixel_on}, 32'd1);
    do_ticks(29);
    chk("blink_t29", {31'd0, pixel_on}, 32'd1);
    do_ticks(1);
    chk("blink_t30", {31'd0, pixel_on}, 32'd0);
    do_ticks(29);
    chk("blink_t59", {31'd0, pixel_on}, 32'd0);
    do_ticks(1);
    chk("blink_t60", {31'd0, pixel_on}, 32'd1);
    do_ticks(SHOW_FRAMES - 61);
    last_tick();
    chk("blink_done", {31'd0, done}, 32'd1);
    step(2);

    // show_req while busy is ignored; cancel aborts without done.
    show_req = 1'b1;
    step(1);
    show_req = 1'b0;
    do_ticks(40);
    show_req = 1'b1;
    step(3);
    chk("busy_req_no_ack", {31'd0, show_ack}, 32'd0);
    show_req = 1'b0;
    do_ticks(SHOW_FRAMES - 41);
    chk("busy_req_still_busy", {31'd0, busy}, 32'd1);
    last_tick();
    chk("busy_req_done", {31'd0, done}, 32'd1);
    step(2);
    show_req = 1'b1;
    step(1);
    show_req = 1'b0;
    do_ticks(40);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    chk("cancel_idle", {31'd0, busy}, 32'd0);
    chk("cancel_no_done", {31'd0, done}, 32'd0);
    step(1);

    // cancel with show_req in IDLE.
    cancel = 1'b1; show_req = 1'b1;
    step(3);
    chk("cancel_req_no_ack", {31'd0, show_ack}, 32'd0);
    cancel = 1'b0;
    step(1);
    chk("drop_cancel_ack", {31'd0, show_ack}, 32'd1);
    show_req = 1'b0;
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(1);

    // Asynchronous reset mid-banner.
    show_req = 1'b1;
    step(1);
    show_req = 1'b0;
    do_ticks(50);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_pixel", {31'd0, pixel_on}, 32'd0);
    step(1);
    rst_n = 1'b1;
    show_req = 1'b1;
    step(1);
    show_req = 1'b0;
    chk("post_rst_ack", {31'd0, show_ack}, 32'd1);
    do_ticks(SHOW_FRAMES - 1);
    last_tick();
    chk("post_rst_done", {31'd0, done}, 32'd1);
    step(1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      show_req   = ($urandom_range(0, 7) == 0);
      cancel     = ($urandom_range(0, 99) == 0);
      frame_tick = ($urandom_range(0, 1) == 0);
      blink_en   = ($urandom_range(0, 1) == 0);
      glyph_hit  = ($urandom_range(0, 2) != 0);
      base_x     = 10'($urandom_range(0, 500));
      base_y     = 10'($urandom_range(0, 400));
      x          = 10'(m_bx + int'($urandom_range(0, 150)) - 5);
      y          = 10'(m_by + int'($urandom_range(0, 60)) - 5);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
